// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache AXI throttle: FSM states, stall
// counter width, a minimal AXI4+ATOP request/response struct pair and the
// saturating stall-counter step function.
package wt_cache_pkg;

  typedef enum logic [1:0] {
    THR_RUN   = 2'd0,
    THR_DRAIN = 2'd1,
    THR_IDLE  = 2'd2
  } throttle_state_e;

  localparam int unsigned WT_THR_STATS_W = 32;

  localparam int unsigned WT_AXI_ID_W   = 4;
  localparam int unsigned WT_AXI_ADDR_W = 64;
  localparam int unsigned WT_AXI_DATA_W = 64;

  typedef struct packed {
    logic [WT_AXI_ID_W-1:0]   id;
    logic [WT_AXI_ADDR_W-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic [5:0]               atop;
  } wt_axi_aw_chan_t;

  typedef struct packed {
    logic [WT_AXI_DATA_W-1:0]   data;
    logic [WT_AXI_DATA_W/8-1:0] strb;
    logic                       last;
  } wt_axi_w_chan_t;

  typedef struct packed {
    logic [WT_AXI_ID_W-1:0] id;
    logic [1:0]             resp;
  } wt_axi_b_chan_t;

  typedef struct packed {
    logic [WT_AXI_ID_W-1:0]   id;
    logic [WT_AXI_ADDR_W-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
  } wt_axi_ar_chan_t;

  typedef struct packed {
    logic [WT_AXI_ID_W-1:0]   id;
    logic [WT_AXI_DATA_W-1:0] data;
    logic [1:0]               resp;
    logic                     last;
  } wt_axi_r_chan_t;

  typedef struct packed {
    wt_axi_aw_chan_t aw;
    logic            aw_valid;
    wt_axi_w_chan_t  w;
    logic            w_valid;
    logic            b_ready;
    wt_axi_ar_chan_t ar;
    logic            ar_valid;
    logic            r_ready;
  } wt_axi_req_t;

  typedef struct packed {
    logic            aw_ready;
    logic            ar_ready;
    logic            w_ready;
    logic            b_valid;
    wt_axi_b_chan_t  b;
    logic            r_valid;
    wt_axi_r_chan_t  r;
  } wt_axi_rsp_t;

  // Next value of a stall counter: clear wins, otherwise count up and stick at all-ones.
  function automatic logic [WT_THR_STATS_W-1:0] wt_thr_stall_next(
    input logic [WT_THR_STATS_W-1:0] cur,
    input logic                      stall,
    input logic                      clr
  );
    logic [WT_THR_STATS_W-1:0] nxt;
    nxt = cur;
    if (clr) begin
      nxt = '0;
    end else if (stall && (cur != '1)) begin
      nxt = cur + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wt_txn_counter.sv
// Outstanding-transaction counter: adds 0..3 per cycle (inc2 weighs 2, inc1
// weighs 1), subtracts one on dec, saturates at zero and flags an underflow.
// The caller keeps the count within Max by gating its increments on full_o.
module wt_txn_counter
  import wt_cache_pkg::*;
#(
  parameter int unsigned Width = 4,
  parameter int unsigned Max   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc2_i,
  input  logic             inc1_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] count_nxt_o,
  output logic             full_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;
  logic [Width+1:0] sum;
  logic             underflow;

  // Net next count; a decrement with nothing counted leaves the count at zero
  always_comb begin
    sum       = {2'b00, count_q} + {{Width{1'b0}}, inc2_i, inc1_i};
    underflow = dec_i && (sum == '0);
    count_d   = Width'(sum);
    if (dec_i && !underflow) begin
      count_d = Width'(sum - 1'b1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign full_o      = ({2'b00, count_q} >= (Width+2)'(Max));

  // A response without a matching request is a protocol error upstream
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !underflow);

endmodule

// File: rtl/wt_axi_txn_throttle.sv
// AXI transaction throttle between the write-through cache master port and
// the interconnect. Limits outstanding reads/writes, holds W beats until
// their AW has been forwarded, and runs a drain sequence for fence/flush.
// Optional stall statistics: define WT_AXI_THROTTLE_STATS_EN.
module wt_axi_txn_throttle
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxRdTxn  = 8,
  parameter int unsigned MaxWrTxn  = 8,
  parameter type         axi_req_t = wt_cache_pkg::wt_axi_req_t,
  parameter type         axi_rsp_t = wt_cache_pkg::wt_axi_rsp_t,
  localparam int unsigned CntWidth =
    $clog2(((MaxRdTxn > MaxWrTxn) ? MaxRdTxn : MaxWrTxn) + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  axi_req_t                  slv_req_i,
  output axi_rsp_t                  slv_resp_o,
  output axi_req_t                  mst_req_o,
  input  axi_rsp_t                  mst_resp_i,
  input  logic                      drain_i,
  output logic                      drained_o,
  output logic [CntWidth-1:0]       rd_outstanding_o,
  output logic [CntWidth-1:0]       wr_outstanding_o,
  input  logic                      stats_clr_i,
  output logic [WT_THR_STATS_W-1:0] rd_stall_cnt_o,
  output logic [WT_THR_STATS_W-1:0] wr_stall_cnt_o
);

  throttle_state_e state_q, state_d;
  logic            run;

  logic [CntWidth-1:0] rd_cnt, rd_cnt_nxt;
  logic [CntWidth-1:0] wr_cnt, wr_cnt_nxt;
  logic [CntWidth-1:0] w_cred, w_cred_nxt;
  logic                rd_full, wr_full, w_cred_full;

  logic rd_ok, wr_ok, rd_room2, aw_atomic, aw_fwd, w_fwd, w_cred_zero;
  logic ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;
  logic rd_inc2, rd_inc1;
  logic w_early, w_cred_inc, w_cred_dec;
  logic w_pend_q, w_pend_d;

  // Admission decisions from registered counts only; the atomic-AW check looks
  // at the incoming AR valid so an AR plus an atomic AW never overshoots MaxRdTxn
  always_comb begin
    rd_room2    = ({2'b00, rd_cnt} + (CntWidth+2)'(2)) <= (CntWidth+2)'(MaxRdTxn);
    aw_atomic   = slv_req_i.aw.atop[5];
    rd_ok       = !rd_full && run;
    wr_ok       = !wr_full && !w_cred_full && run;
    aw_fwd      = wr_ok && (!aw_atomic || (rd_ok && (!slv_req_i.ar_valid || rd_room2)));
    w_cred_zero = (w_cred == '0);
    w_fwd       = !w_cred_zero || (slv_req_i.aw_valid && aw_fwd && !w_pend_q);
  end

  // Handshakes and counter steps; a W last that overtakes its own AW handshake
  // is remembered so that the later AW does not mint a stale credit
  always_comb begin
    ar_hs      = slv_req_i.ar_valid && rd_ok && mst_resp_i.ar_ready;
    aw_hs      = slv_req_i.aw_valid && aw_fwd && mst_resp_i.aw_ready;
    w_last_hs  = slv_req_i.w_valid && w_fwd && mst_resp_i.w_ready && slv_req_i.w.last;
    r_last_hs  = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
    b_hs       = mst_resp_i.b_valid && slv_req_i.b_ready;
    rd_inc2    = ar_hs && aw_hs && aw_atomic;
    rd_inc1    = ar_hs ^ (aw_hs && aw_atomic);
    w_early    = w_last_hs && w_cred_zero && !aw_hs;
    w_cred_inc = aw_hs && !w_pend_q;
    w_cred_dec = w_last_hs && !w_early;
    w_pend_d   = w_pend_q ? !aw_hs : w_early;
  end

  wt_txn_counter #(
    .Width (CntWidth),
    .Max   (MaxRdTxn)
  ) i_rd_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc2_i      (rd_inc2),
    .inc1_i      (rd_inc1),
    .dec_i       (r_last_hs),
    .count_o     (rd_cnt),
    .count_nxt_o (rd_cnt_nxt),
    .full_o      (rd_full)
  );

  wt_txn_counter #(
    .Width (CntWidth),
    .Max   (MaxWrTxn)
  ) i_wr_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc2_i      (1'b0),
    .inc1_i      (aw_hs),
    .dec_i       (b_hs),
    .count_o     (wr_cnt),
    .count_nxt_o (wr_cnt_nxt),
    .full_o      (wr_full)
  );

  // W credits never exceed forwarded AWs, so the same limit bounds them and
  // keeps the credit counter safe even if a slave answers B early
  wt_txn_counter #(
    .Width (CntWidth),
    .Max   (MaxWrTxn)
  ) i_w_cred (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc2_i      (1'b0),
    .inc1_i      (w_cred_inc),
    .dec_i       (w_cred_dec),
    .count_o     (w_cred),
    .count_nxt_o (w_cred_nxt),
    .full_o      (w_cred_full)
  );

  // Early-W flag register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_pend_q <= 1'b0;
    end else begin
      w_pend_q <= w_pend_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= THR_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; drain completes on the cycle the last response is accepted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      THR_RUN: begin
        if (drain_i) state_d = THR_DRAIN;
      end
      THR_DRAIN: begin
        if (!drain_i) begin
          state_d = THR_RUN;
        end else if ((rd_cnt_nxt == '0) && (wr_cnt_nxt == '0) &&
                     (w_cred_nxt == '0) && !w_pend_d) begin
          state_d = THR_IDLE;
        end
      end
      THR_IDLE: begin
        if (!drain_i) state_d = THR_RUN;
      end
      default: state_d = THR_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    run       = (state_q == THR_RUN);
    drained_o = (state_q == THR_IDLE);
  end

  // Channel pass-through with AR/AW/W gating; R and B flow untouched
  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid && rd_ok;
    mst_req_o.aw_valid  = slv_req_i.aw_valid && aw_fwd;
    mst_req_o.w_valid   = slv_req_i.w_valid && w_fwd;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready && rd_ok;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_fwd;
    slv_resp_o.w_ready  = mst_resp_i.w_ready && w_fwd;
  end

  assign rd_outstanding_o = rd_cnt;
  assign wr_outstanding_o = wr_cnt;

`ifdef WT_AXI_THROTTLE_STATS_EN
  logic [WT_THR_STATS_W-1:0] rd_stall_q, rd_stall_d;
  logic [WT_THR_STATS_W-1:0] wr_stall_q, wr_stall_d;

  // Stall counters: cycles a request is presented but held by the throttle
  always_comb begin
    rd_stall_d = wt_thr_stall_next(rd_stall_q, slv_req_i.ar_valid && !rd_ok, stats_clr_i);
    wr_stall_d = wt_thr_stall_next(wr_stall_q, slv_req_i.aw_valid && !aw_fwd, stats_clr_i);
  end

  // Stall counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else begin
      rd_stall_q <= rd_stall_d;
      wr_stall_q <= wr_stall_d;
    end
  end

  assign rd_stall_cnt_o = rd_stall_q;
  assign wr_stall_cnt_o = wr_stall_q;
`else
  logic unused_stats;
  assign unused_stats   = stats_clr_i;
  assign rd_stall_cnt_o = '0;
  assign wr_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wt_axi_txn_throttle.sv
// Directed bench for wt_axi_txn_throttle (MaxRdTxn=4, MaxWrTxn=2).
module tb_wt_axi_txn_throttle;
  import wt_cache_pkg::*;

  localparam int unsigned RD_MAX = 4;
  localparam int unsigned WR_MAX = 2;
  localparam int unsigned CW     = $clog2(RD_MAX + 1);
`ifdef WT_AXI_THROTTLE_STATS_EN
  localparam int STALL_EN = 1;
`else
  localparam int STALL_EN = 0;
`endif

  logic                      clk_i;
  logic                      rst_ni;
  wt_axi_req_t               slv_req;
  wt_axi_rsp_t               slv_resp;
  wt_axi_req_t               mst_req;
  wt_axi_rsp_t               mst_resp;
  logic                      drain;
  logic                      drained;
  logic [CW-1:0]             rd_out;
  logic [CW-1:0]             wr_out;
  logic                      stats_clr;
  logic [WT_THR_STATS_W-1:0] rd_stall;
  logic [WT_THR_STATS_W-1:0] wr_stall;

  int checks;
  int failures;

  wt_axi_txn_throttle #(
    .MaxRdTxn (RD_MAX),
    .MaxWrTxn (WR_MAX)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .slv_req_i        (slv_req),
    .slv_resp_o       (slv_resp),
    .mst_req_o        (mst_req),
    .mst_resp_i       (mst_resp),
    .drain_i          (drain),
    .drained_o        (drained),
    .rd_outstanding_o (rd_out),
    .wr_outstanding_o (wr_out),
    .stats_clr_i      (stats_clr),
    .rd_stall_cnt_o   (rd_stall),
    .wr_stall_cnt_o   (wr_stall)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_ni    = 1'b0;
    drain     = 1'b0;
    stats_clr = 1'b0;
    slv_req   = '0;
    mst_resp  = '0;
    slv_req.r_ready   = 1'b1;
    slv_req.b_ready   = 1'b1;
    mst_resp.ar_ready = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    mst_resp.r.last   = 1'b1;

    // Reset state
    #12;
    check("rst_rd_cnt", 32'(rd_out), 0);
    check("rst_wr_cnt", 32'(wr_out), 0);
    check("rst_drained", 32'(drained), 0);
    check("rst_rd_stall", rd_stall, 0);
    rst_ni = 1'b1;
    tick();

    // 1: fill reads to the limit, next AR held, freed one cycle after R last
    slv_req.ar_valid = 1'b1;
    #1;
    check("t1_ar_fwd", 32'(mst_req.ar_valid), 1);
    repeat (4) tick();
    check("t1_rd_full", 32'(rd_out), 4);
    check("t1_ar_held", 32'(mst_req.ar_valid), 0);
    check("t1_ar_ready_held", 32'(slv_resp.ar_ready), 0);
    tick();
    check("t1_rd_still_full", 32'(rd_out), 4);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b0;
    tick();
    check("t1_r_not_last", 32'(rd_out), 4);
    mst_resp.r.last = 1'b1;
    #1;
    check("t1_ar_held_same_cycle_dec", 32'(mst_req.ar_valid), 0);
    tick();
    mst_resp.r_valid = 1'b0;
    #1;
    check("t1_rd_after_r", 32'(rd_out), 3);
    check("t1_ar_released", 32'(mst_req.ar_valid), 1);
    tick();
    check("t1_rd_refill", 32'(rd_out), 4);
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    repeat (4) tick();
    mst_resp.r_valid = 1'b0;
    #1;
    check("t1_rd_empty", 32'(rd_out), 0);

    // 2: atomic AW counts as read and write
    slv_req.aw_valid = 1'b1;
    slv_req.aw.atop  = 6'b100000;
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b1;
    #1;
    check("t2_aw_fwd", 32'(mst_req.aw_valid), 1);
    check("t2_w_with_aw", 32'(mst_req.w_valid), 1);
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.aw.atop  = 6'b000000;
    slv_req.w_valid  = 1'b0;
    #1;
    check("t2_rd_cnt", 32'(rd_out), 1);
    check("t2_wr_cnt", 32'(wr_out), 1);
    mst_resp.r_valid = 1'b1;
    tick();
    mst_resp.r_valid = 1'b0;
    #1;
    check("t2_rd_after_r", 32'(rd_out), 0);
    check("t2_wr_after_r", 32'(wr_out), 1);
    mst_resp.b_valid = 1'b1;
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    check("t2_wr_after_b", 32'(wr_out), 0);

    // 2b: AR plus atomic AW at rd_cnt=3 would exceed 4 -> AR goes, AW held
    slv_req.ar_valid = 1'b1;
    repeat (3) tick();
    check("t2b_rd3", 32'(rd_out), 3);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.atop  = 6'b100000;
    #1;
    check("t2b_ar_fwd", 32'(mst_req.ar_valid), 1);
    check("t2b_aw_held", 32'(mst_req.aw_valid), 0);
    tick();
    slv_req.ar_valid = 1'b0;
    #1;
    check("t2b_rd4", 32'(rd_out), 4);
    check("t2b_wr0", 32'(wr_out), 0);
    check("t2b_aw_held_full", 32'(mst_req.aw_valid), 0);
    mst_resp.r_valid = 1'b1;
    tick();
    mst_resp.r_valid = 1'b0;
    #1;
    check("t2b_aw_fwd_alone", 32'(mst_req.aw_valid), 1);
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.aw.atop  = 6'b000000;
    #1;
    check("t2b_rd_after_aw", 32'(rd_out), 4);
    check("t2b_wr_after_aw", 32'(wr_out), 1);
    slv_req.w_valid = 1'b1;
    #1;
    check("t2b_w_on_credit", 32'(mst_req.w_valid), 1);
    tick();
    slv_req.w_valid  = 1'b0;
    mst_resp.r_valid = 1'b1;
    repeat (4) tick();
    mst_resp.r_valid = 1'b0;
    mst_resp.b_valid = 1'b1;
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    check("t2b_rd_clean", 32'(rd_out), 0);
    check("t2b_wr_clean", 32'(wr_out), 0);

    // 3: writes at limit hold both AW and W; freeing a B releases them together
    slv_req.aw_valid = 1'b1;
    slv_req.w_valid  = 1'b1;
    repeat (2) tick();
    check("t3_wr_full", 32'(wr_out), 2);
    check("t3_aw_held", 32'(mst_req.aw_valid), 0);
    check("t3_w_held", 32'(mst_req.w_valid), 0);
    check("t3_w_ready_held", 32'(slv_resp.w_ready), 0);
    tick();
    check("t3_wr_still_full", 32'(wr_out), 2);
    mst_resp.b_valid = 1'b1;
    #1;
    check("t3_aw_held_same_cycle_dec", 32'(mst_req.aw_valid), 0);
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    check("t3_wr_after_b", 32'(wr_out), 1);
    check("t3_aw_released", 32'(mst_req.aw_valid), 1);
    check("t3_w_released", 32'(mst_req.w_valid), 1);
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    #1;
    check("t3_wr_refill", 32'(wr_out), 2);
    mst_resp.b_valid = 1'b1;
    repeat (2) tick();
    mst_resp.b_valid = 1'b0;
    #1;
    check("t3_wr_clean", 32'(wr_out), 0);

    // 4: drain with 4 reads outstanding
    slv_req.ar_valid = 1'b1;
    repeat (4) tick();
    slv_req.ar_valid = 1'b0;
    drain = 1'b1;
    #1;
    check("t4_rd4", 32'(rd_out), 4);
    tick();
    slv_req.ar_valid = 1'b1;
    mst_resp.r_valid = 1'b1;
    tick();
    check("t4_ar_held_in_drain", 32'(mst_req.ar_valid), 0);
    check("t4_not_drained", 32'(drained), 0);
    repeat (2) tick();
    check("t4_rd1", 32'(rd_out), 1);
    check("t4_not_drained_rd1", 32'(drained), 0);
    tick();
    mst_resp.r_valid = 1'b0;
    #1;
    check("t4_rd0", 32'(rd_out), 0);
    check("t4_drained", 32'(drained), 1);
    check("t4_ar_held_idle", 32'(mst_req.ar_valid), 0);
    drain = 1'b0;
    tick();
    check("t4_undrained", 32'(drained), 0);
    check("t4_ar_fwd_run", 32'(mst_req.ar_valid), 1);
    slv_req.ar_valid = 1'b0;

    // 5: drain abort, then async reset mid-operation
    slv_req.ar_valid = 1'b1;
    repeat (3) tick();
    slv_req.ar_valid = 1'b0;
    #1;
    check("t5_rd3", 32'(rd_out), 3);
    drain = 1'b1;
    tick();
    drain = 1'b0;
    slv_req.ar_valid = 1'b1;
    #1;
    check("t5_ar_held_drain", 32'(mst_req.ar_valid), 0);
    tick();
    check("t5_abort_not_drained", 32'(drained), 0);
    check("t5_abort_run", 32'(mst_req.ar_valid), 1);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_rd", 32'(rd_out), 0);
    check("t5_rst_drained", 32'(drained), 0);
    rst_ni = 1'b1;
    #1;
    check("t5_ar_after_rst", 32'(mst_req.ar_valid), 1);

    // 6: stall statistics
    repeat (4) tick();
    check("t6_rd4", 32'(rd_out), 4);
    repeat (10) tick();
    check("t6_rd_stall10", rd_stall, 32'(10 * STALL_EN));
    check("t6_wr_stall0", wr_stall, 0);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    #1;
    check("t6_rd_stall_clr", rd_stall, 0);
    tick();
    check("t6_rd_stall_restart", rd_stall, 32'(STALL_EN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
